bus_ready_generator: RTL and testbench
======================================

// Module: bus_ready_generator
// PURPOSE
// - Ready/wait-state logic feeding the bus arbiter: produces dma_ready for the 8237 and processor_ready for the CPU/8284 RDY path.
// - Stretches every CPU or DMA command with a programmed number of cpu_clock wait states.
// - Also holds a command while the expansion channel drives io_channel_ready low.
// PARAMETERS
// - IO_WAIT_STATES   1    wait states added to CPU I/O read/write commands (0..15)
// - MEM_WAIT_STATES  0    wait states added to CPU memory read/write commands (0..15)
// - DMA_WAIT_STATES  1    wait states added to DMA-owned commands (0..15)
// - TIMEOUT_CYCLES   255  cpu_clock cycles of io_channel_ready low before forced release (READY_TIMEOUT_EN only)
// PORTS
// - clock             in   1  system clock
// - reset_n           in   1  synchronous active-low reset
// - cpu_clock         in   1  CPU clock level; sampled on clock, rising edge = posedge of prev/current
// - address_enable_n  in   1  0 = CPU owns the bus, 1 = DMA/external owns the bus
// - dma_acknowledge_n in   4  active-low DACK from the 8237
// - io_read_n         in   1  resolved bus command, active low
// - io_write_n        in   1  resolved bus command, active low
// - memory_read_n     in   1  resolved bus command, active low
// - memory_write_n    in   1  resolved bus command, active low
// - io_channel_ready  in   1  expansion-bus ready, 1 = ready
// - processor_ready   out  1  1 = CPU cycle may complete
// - dma_ready         out  1  1 = DMA cycle may complete
// - bus_timeout       out  1  one-clock pulse on forced release (READY_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
// - Timing base:
//   - cpu_tick = ~prev_cpu_clock & cpu_clock.
//   - Counters and state advance only on cpu_tick.
//   - Command-edge detection runs on every clock.
// - Reset (reset_n=0 at clock edge): processor_ready=1, dma_ready=1, bus_timeout=0, state=IDLE, counter=0, prev_cpu_clock=0.
// - cmd_active = ~(io_read_n & io_write_n & memory_read_n & memory_write_n).
// - Owner:
//   - DMA when address_enable_n=1 and ~&dma_acknowledge_n.
//   - CPU when address_enable_n=0.
//   - Otherwise none; commands with no owner are ignored and both readies stay 1.
// - Wait-state count selected at command start:
//   - DMA owner: DMA_WAIT_STATES.
//   - CPU I/O command: IO_WAIT_STATES.
//   - CPU memory command: MEM_WAIT_STATES.
// - State machine:
//   - IDLE: on the cmd_active rising edge (clock-level) with a valid owner:
//     - load counter with the selected count;
//     - drive the owner's ready to 0 in the same clock;
//     - go to WAIT.
//   - WAIT:
//     - On each cpu_tick, decrement the counter if non-zero.
//     - When counter==0 and io_channel_ready=1 at a cpu_tick, the owner's ready becomes 1 and the state goes to RELEASE.
//     - A count of 0 therefore still holds ready low until the first cpu_tick (one-tick minimum sample).
//   - RELEASE: ready stays 1. When cmd_active=0, go to IDLE.
//   - Command deasserts while in WAIT (aborted cycle): go to IDLE immediately, restore both readies to 1, clear the counter.
// - Readies:
//   - Only the owner's ready is ever driven low; the other output stays 1.
//   - processor_ready and dma_ready are never low simultaneously.
//   - Owner change mid-WAIT is not a legal bus condition; the block keeps the owner latched at command start.
// - Counter is 4 bits and saturates at 0 (no wrap).
// - Back-to-back commands: a new command is accepted only from IDLE; the command must first pass through a cmd_active=0 clock.
// - Reset asserted mid-WAIT: both readies read 1 on the next clock, with no glitch low afterwards.
// CONFIGURATION
// - READY_TIMEOUT_EN defined:
//   - A 16-bit timeout counter runs in WAIT while counter==0 and io_channel_ready=0, incrementing per cpu_tick.
//   - On reaching TIMEOUT_CYCLES: the owner's ready is forced to 1, bus_timeout pulses high for one clock, and the state goes to RELEASE.
//   - The timeout counter clears in IDLE.
// - READY_TIMEOUT_EN undefined:
//   - No timeout logic; WAIT holds indefinitely while io_channel_ready=0.
//   - bus_timeout is constant 0.
// TESTING
// - Reset: hold reset_n=0 for 3 clocks -> processor_ready=1, dma_ready=1, bus_timeout=0.
// - CPU I/O read (address_enable_n=0, io_read_n=0, IO_WAIT_STATES=1, io_channel_ready=1):
//   - processor_ready falls in the same clock;
//   - rises at the 2nd cpu_tick;
//   - dma_ready stays 1 throughout.
// - DMA memory write (address_enable_n=1, dma_acknowledge_n=4'b1110, DMA_WAIT_STATES=1):
//   - dma_ready low for 2 cpu_ticks, then 1;
//   - processor_ready stays 1.
// - CPU memory read with MEM_WAIT_STATES=0 and io_channel_ready held 0 for 5 cpu_ticks:
//   - processor_ready low for 6 cpu_ticks, rising at the tick after io_channel_ready returns to 1.
// - Abort: drop io_write_n to 1 mid-WAIT -> processor_ready=1 on the next clock, state IDLE; a new command 1 clock later is accepted.
// - READY_TIMEOUT_EN, TIMEOUT_CYCLES=4, io_channel_ready stuck at 0:
//   - processor_ready rises after 4 stalled cpu_ticks;
//   - bus_timeout is high for exactly 1 clock.

Source files
------------

// File: rtl/bus_ready_generator.sv
// Wait-state and ready generator for the CPU (processor_ready) and 8237 DMA (dma_ready) bus paths.
// Optional build macro READY_TIMEOUT_EN adds a forced release when io_channel_ready stays low too long.
module bus_ready_generator #(
  parameter int unsigned IO_WAIT_STATES  = 1,
  parameter int unsigned MEM_WAIT_STATES = 0,
  parameter int unsigned DMA_WAIT_STATES = 1
`ifdef READY_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES  = 255
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_clock,
  input  logic       address_enable_n,
  input  logic [3:0] dma_acknowledge_n,
  input  logic       io_read_n,
  input  logic       io_write_n,
  input  logic       memory_read_n,
  input  logic       memory_write_n,
  input  logic       io_channel_ready,
  output logic       processor_ready,
  output logic       dma_ready,
  output logic       bus_timeout
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_prev_cpu_clock;
  logic             r_prev_cmd;
  logic             r_processor_ready;
  logic             r_dma_ready;

  logic             w_cmd_active;
  logic             w_cmd_rise;
  logic             w_cpu_tick;
  logic             w_owner_cpu;
  logic             w_owner_dma;
  logic             w_io_cmd;
  logic [CNT_W-1:0] w_start_count;

  assign w_cmd_active = ~(io_read_n & io_write_n & memory_read_n & memory_write_n);
  assign w_cmd_rise   = w_cmd_active & ~r_prev_cmd;
  assign w_cpu_tick   = ~r_prev_cpu_clock & cpu_clock;
  assign w_owner_cpu  = ~address_enable_n;
  assign w_owner_dma  = address_enable_n & ~(&dma_acknowledge_n);
  assign w_io_cmd     = ~(io_read_n & io_write_n);

  // Wait-state count chosen by bus owner and command type at command start
  always_comb begin
    w_start_count = CNT_W'(MEM_WAIT_STATES);
    if (w_owner_dma) begin
      w_start_count = CNT_W'(DMA_WAIT_STATES);
    end else if (w_io_cmd) begin
      w_start_count = CNT_W'(IO_WAIT_STATES);
    end
  end

`ifdef READY_TIMEOUT_EN
  localparam int unsigned TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_count;
  logic             r_bus_timeout;

  assign bus_timeout = r_bus_timeout;
`else
  assign bus_timeout = 1'b0;
`endif

  assign processor_ready = r_processor_ready;
  assign dma_ready       = r_dma_ready;

  // Command edge tracking runs through reset so a command held across reset is not re-accepted
  always_ff @(posedge clock) begin
    r_prev_cmd <= w_cmd_active;
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_count           <= '0;
      r_prev_cpu_clock  <= 1'b0;
      r_processor_ready <= 1'b1;
      r_dma_ready       <= 1'b1;
`ifdef READY_TIMEOUT_EN
      r_tmo_count       <= '0;
      r_bus_timeout     <= 1'b0;
`endif
    end else begin
      r_prev_cpu_clock <= cpu_clock;
`ifdef READY_TIMEOUT_EN
      r_bus_timeout    <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
`ifdef READY_TIMEOUT_EN
          r_tmo_count <= '0;
`endif
          if (w_cmd_rise && (w_owner_cpu || w_owner_dma)) begin
            r_count <= w_start_count;
            r_state <= S_WAIT;
            if (w_owner_dma) begin
              r_dma_ready <= 1'b0;
            end else begin
              r_processor_ready <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (!w_cmd_active) begin
            r_state           <= S_IDLE;
            r_count           <= '0;
            r_processor_ready <= 1'b1;
            r_dma_ready       <= 1'b1;
          end else if (w_cpu_tick) begin
            if (r_count != '0) begin
              r_count <= r_count - CNT_W'(1);
            end else if (io_channel_ready) begin
              r_state           <= S_RELEASE;
              r_processor_ready <= 1'b1;
              r_dma_ready       <= 1'b1;
`ifdef READY_TIMEOUT_EN
            end else if (r_tmo_count == TMO_LAST) begin
              r_state           <= S_RELEASE;
              r_processor_ready <= 1'b1;
              r_dma_ready       <= 1'b1;
              r_bus_timeout     <= 1'b1;
            end else begin
              r_tmo_count <= r_tmo_count + TMO_W'(1);
`endif
            end
          end
        end
        S_RELEASE: begin
          if (!w_cmd_active) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state           <= S_IDLE;
          r_processor_ready <= 1'b1;
          r_dma_ready       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ready_generator.sv
// Bench for bus_ready_generator: directed bus cycles plus randomized traffic against a tick-counting model.
module tb_bus_ready_generator;

  localparam int unsigned IO_WS  = 1;
  localparam int unsigned MEM_WS = 0;
  localparam int unsigned DMA_WS = 1;
`ifdef READY_TIMEOUT_EN
  localparam int unsigned TMO    = 4;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_clock = 1'b0;
  logic       address_enable_n = 1'b0;
  logic [3:0] dma_acknowledge_n = 4'hF;
  logic       io_read_n = 1'b1;
  logic       io_write_n = 1'b1;
  logic       memory_read_n = 1'b1;
  logic       memory_write_n = 1'b1;
  logic       io_channel_ready = 1'b1;
  logic       processor_ready;
  logic       dma_ready;
  logic       bus_timeout;

  bus_ready_generator #(
    .IO_WAIT_STATES (IO_WS),
    .MEM_WAIT_STATES(MEM_WS),
    .DMA_WAIT_STATES(DMA_WS)
`ifdef READY_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cpu_clock        (cpu_clock),
    .address_enable_n (address_enable_n),
    .dma_acknowledge_n(dma_acknowledge_n),
    .io_read_n        (io_read_n),
    .io_write_n       (io_write_n),
    .memory_read_n    (memory_read_n),
    .memory_write_n   (memory_write_n),
    .io_channel_ready (io_channel_ready),
    .processor_ready  (processor_ready),
    .dma_ready        (dma_ready),
    .bus_timeout      (bus_timeout)
  );

  always #5 clock = ~clock;

  int n_err = 0;
  int n_checks = 0;

  // Model: phase 0 idle, 1 holding, 2 released; counts elapsed ticks against the required wait count
  int   m_phase = 0;
  int   m_need = 0;
  int   m_elapsed = 0;
`ifdef READY_TIMEOUT_EN
  int   m_stall = 0;
`endif
  logic m_pr = 1'b1;
  logic m_dr = 1'b1;
  logic m_to = 1'b0;
  logic m_prev_cpu = 1'b0;
  logic m_prev_cmd = 1'b0;
  bit   last_tick = 1'b0;
  bit   auto_cpu = 1'b1;
  int   div = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model on the current inputs, clock once, then compare outputs
  task automatic step();
    logic cmd, tick, own_cpu, own_dma;
    cmd     = ~(io_read_n & io_write_n & memory_read_n & memory_write_n);
    tick    = ~m_prev_cpu & cpu_clock;
    own_cpu = ~address_enable_n;
    own_dma = address_enable_n & (dma_acknowledge_n != 4'hF);
    if (!reset_n) begin
      m_phase = 0; m_pr = 1'b1; m_dr = 1'b1; m_to = 1'b0; m_prev_cpu = 1'b0;
    end else begin
      m_to = 1'b0;
      case (m_phase)
        0: begin
`ifdef READY_TIMEOUT_EN
          m_stall = 0;
`endif
          if (cmd && !m_prev_cmd && (own_cpu || own_dma)) begin
            m_need = own_dma ? int'(DMA_WS) : ((!io_read_n || !io_write_n) ? int'(IO_WS) : int'(MEM_WS));
            m_elapsed = 0;
            m_phase = 1;
            if (own_dma) m_dr = 1'b0; else m_pr = 1'b0;
          end
        end
        1: begin
          if (!cmd) begin
            m_phase = 0; m_pr = 1'b1; m_dr = 1'b1;
          end else if (tick) begin
            if (m_elapsed < m_need) m_elapsed++;
            else if (io_channel_ready) begin
              m_phase = 2; m_pr = 1'b1; m_dr = 1'b1;
`ifdef READY_TIMEOUT_EN
            end else if (m_stall + 1 >= int'(TMO)) begin
              m_phase = 2; m_pr = 1'b1; m_dr = 1'b1; m_to = 1'b1;
            end else begin
              m_stall++;
`endif
            end
          end
        end
        default: if (!cmd) m_phase = 0;
      endcase
      m_prev_cpu = cpu_clock;
    end
    m_prev_cmd = cmd;
    @(posedge clock);
    #1;
    last_tick = tick;
    chk("processor_ready", processor_ready, m_pr);
    chk("dma_ready", dma_ready, m_dr);
    chk("bus_timeout", bus_timeout, m_to);
    chk("ready_exclusive", processor_ready | dma_ready, 1'b1);
    if (auto_cpu) begin
      div++;
      cpu_clock = div[1];
    end
  endtask

  task automatic go_idle();
    io_read_n = 1'b1; io_write_n = 1'b1; memory_read_n = 1'b1; memory_write_n = 1'b1;
    io_channel_ready = 1'b1;
    repeat (3) step();
  endtask

  // Step until the watched ready rises; channel ready returns after 'stall' ticks (negative = never)
  task automatic wait_release(input bit dma, input int stall, output int ticks, output int pulses);
    ticks = 0;
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (last_tick) ticks++;
      if (bus_timeout === 1'b1) pulses++;
      if (stall >= 0 && ticks >= stall) io_channel_ready = 1'b1;
      if ((dma ? dma_ready : processor_ready) === 1'b1) break;
    end
  endtask

  int ticks, pulses;

  initial begin
    // Reset held three clocks
    repeat (3) step();
    chk("reset_processor_ready", processor_ready, 1'b1);
    chk("reset_dma_ready", dma_ready, 1'b1);
    chk("reset_bus_timeout", bus_timeout, 1'b0);
    reset_n = 1'b1;
    go_idle();

    // CPU I/O read: falls at once, rises on the second tick
    address_enable_n = 1'b0; io_read_n = 1'b0;
    step();
    chk("cpu_io_fall", processor_ready, 1'b0);
    wait_release(1'b0, 0, ticks, pulses);
    chk_int("cpu_io_ticks", ticks, 2);
    go_idle();

    // DMA memory write on channel 0
    address_enable_n = 1'b1; dma_acknowledge_n = 4'b1110; memory_write_n = 1'b0;
    step();
    chk("dma_fall", dma_ready, 1'b0);
    chk("dma_cpu_ready_high", processor_ready, 1'b1);
    wait_release(1'b1, 0, ticks, pulses);
    chk_int("dma_ticks", ticks, 2);
    go_idle();

    // No owner: command ignored
    dma_acknowledge_n = 4'hF; io_read_n = 1'b0;
    repeat (6) step();
    chk("no_owner_cpu", processor_ready, 1'b1);
    chk("no_owner_dma", dma_ready, 1'b1);
    go_idle();

    // CPU memory read, zero wait states, channel not ready for five ticks
    address_enable_n = 1'b0; memory_read_n = 1'b0; io_channel_ready = 1'b0;
    step();
    chk("mem_fall", processor_ready, 1'b0);
    wait_release(1'b0, 5, ticks, pulses);
    chk_int("mem_stall_ticks", ticks, 6);
    go_idle();

    // Abort mid-wait, then re-issue one clock later
    io_channel_ready = 1'b0; io_write_n = 1'b0;
    repeat (7) step();
    chk("abort_held", processor_ready, 1'b0);
    io_write_n = 1'b1;
    step();
    chk("abort_release", processor_ready, 1'b1);
    io_write_n = 1'b0;
    step();
    chk("abort_reaccept", processor_ready, 1'b0);
    io_channel_ready = 1'b1;
    wait_release(1'b0, 0, ticks, pulses);
    chk_int("abort_reaccept_ticks", ticks, 2);
    go_idle();

    // Reset mid-wait with the command still held: no relaunch afterwards
    io_channel_ready = 1'b0; io_read_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    chk("reset_mid_wait", processor_ready, 1'b1);
    reset_n = 1'b1;
    repeat (8) step();
    chk("reset_no_glitch", processor_ready, 1'b1);
    go_idle();

`ifdef READY_TIMEOUT_EN
    // Channel stuck not-ready: forced release after TMO stalled ticks
    memory_read_n = 1'b0; io_channel_ready = 1'b0;
    step();
    wait_release(1'b0, -1, ticks, pulses);
    chk_int("timeout_ticks", ticks, int'(TMO));
    step();
    if (bus_timeout === 1'b1) pulses++;
    chk_int("timeout_pulses", pulses, 1);
    go_idle();
`endif

    // Randomized traffic
    auto_cpu = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      cpu_clock = 1'($urandom_range(0, 1));
      io_channel_ready = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) begin
        logic [3:0] c;
        c = 4'hF;
        if ($urandom_range(0, 2) != 0) c[$urandom_range(0, 3)] = 1'b0;
        {io_read_n, io_write_n, memory_read_n, memory_write_n} = c;
        if (c == 4'hF && $urandom_range(0, 1) == 1) begin
          address_enable_n = 1'($urandom_range(0, 1));
          dma_acknowledge_n = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
